// File: rtl/qa_7seg_pkg.sv
// Shared constants for the 7-segment frame decoder: glyph patterns (active-high a..g),
// digit/byte counts and the capture FSM encoding.
package qa_7seg_pkg;
  localparam int NUM_DIGITS = 6;
  localparam int NUM_BYTES  = 3;
  localparam int BUS_W      = 7 * NUM_DIGITS;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_PEND   = 1'b1
  } state_e;
endpackage

// File: rtl/qa_7seg_glyph_decoder.sv
// Combinational glyph lookup: active-high segment pattern -> {legal, blank, nibble}.
module qa_7seg_glyph_decoder
  import qa_7seg_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic       legal_o,
  output logic       blank_o,
  output logic [3:0] nib_o
);
  always_comb begin
    legal_o = 1'b1;
    nib_o   = 4'h0;
    blank_o = (pat_i == SEG_BLANK);
    case (pat_i)
      GLYPH_0: nib_o = 4'h0;
      GLYPH_1: nib_o = 4'h1;
      GLYPH_2: nib_o = 4'h2;
      GLYPH_3: nib_o = 4'h3;
      GLYPH_4: nib_o = 4'h4;
      GLYPH_5: nib_o = 4'h5;
      GLYPH_6: nib_o = 4'h6;
      GLYPH_7: nib_o = 4'h7;
      GLYPH_8: nib_o = 4'h8;
      GLYPH_9: nib_o = 4'h9;
      GLYPH_A: nib_o = 4'hA;
      GLYPH_B: nib_o = 4'hB;
      GLYPH_C: nib_o = 4'hC;
      GLYPH_D: nib_o = 4'hD;
      GLYPH_E: nib_o = 4'hE;
      GLYPH_F: nib_o = 4'hF;
      default: legal_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/qa_7seg_frame_decoder.sv
// Samples the active-low 6-digit segment bus, waits for stability, decodes each new frame and
// hands it downstream over valid/ready. Define QA_7SEG_DEC_SYNC_EN to add a 2-flop input sync.
module qa_7seg_frame_decoder
  import qa_7seg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clkIn,
  input  logic              nResetIn,
  input  logic [BUS_W-1:0]  segmentsIn,
  output logic              validOut,
  input  logic              readyIn,
  output logic [2:0]        byteEnableOut,
  output logic [23:0]       byteDataOut,
  output logic [5:0]        invalidOut
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES);

  logic [BUS_W-1:0] bus_s;

`ifdef QA_7SEG_DEC_SYNC_EN
  logic [BUS_W-1:0] sync1_q, sync2_q;
  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= segmentsIn;
      sync2_q <= sync1_q;
    end
  end
  assign bus_s = sync2_q;
`else
  assign bus_s = segmentsIn;
`endif

  logic [BUS_W-1:0] seg_q, last_seg_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             have_last_q;
  state_e           state_q, state_d;
  logic             capture;
  logic [NUM_BYTES-1:0]       en_q, dec_en;
  logic [NUM_BYTES-1:0][7:0]  data_q, dec_data;
  logic [NUM_BYTES-1:0][1:0]  inv_q, dec_inv;

  logic [NUM_DIGITS-1:0]      legal, blank;
  logic [NUM_DIGITS-1:0][3:0] nib;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    qa_7seg_glyph_decoder u_glyph (
      .pat_i   (~seg_q[7*k +: 7]),
      .legal_o (legal[k]),
      .blank_o (blank[k]),
      .nib_o   (nib[k])
    );
  end

  // A half-lit byte is flagged on both digits; illegal glyphs decode as zero.
  always_comb begin
    dec_en   = '0;
    dec_data = '0;
    dec_inv  = '0;
    for (int j = 0; j < NUM_BYTES; j++) begin
      if (blank[2*j] && blank[2*j+1]) begin
        dec_inv[j] = 2'b00;
      end else if (blank[2*j] || blank[2*j+1]) begin
        dec_inv[j] = 2'b11;
      end else begin
        dec_en[j]   = 1'b1;
        dec_inv[j]  = {~legal[2*j+1], ~legal[2*j]};
        dec_data[j] = {legal[2*j+1] ? nib[2*j+1] : 4'h0,
                       legal[2*j]   ? nib[2*j]   : 4'h0};
      end
    end
  end

  always_comb begin
    if (bus_s != seg_q)       cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                      cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == CNT_MAX && (!have_last_q || seg_q != last_seg_q)) begin
          capture = 1'b1;
          state_d = ST_PEND;
        end
      end
      ST_PEND: if (readyIn) state_d = ST_SETTLE;
      default: state_d = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      seg_q       <= '1;
      cnt_q       <= '0;
      last_seg_q  <= '1;
      have_last_q <= 1'b0;
      state_q     <= ST_SETTLE;
      en_q        <= '0;
      data_q      <= '0;
      inv_q       <= '0;
    end else begin
      seg_q   <= bus_s;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      if (capture) begin
        last_seg_q  <= seg_q;
        have_last_q <= 1'b1;
        en_q        <= dec_en;
        data_q      <= dec_data;
        inv_q       <= dec_inv;
      end
    end
  end

  assign validOut      = (state_q == ST_PEND);
  assign byteEnableOut = en_q;
  assign byteDataOut   = data_q;
  assign invalidOut    = inv_q;
endmodule

// File: tb/tb_qa_7seg_frame_decoder.sv
// Directed bench for qa_7seg_frame_decoder: frames are queued as they are driven and
// checked as each valid/ready transfer happens.
module tb_qa_7seg_frame_decoder;
  typedef struct packed {
    logic [2:0]  en;
    logic [23:0] data;
    logic [5:0]  inv;
  } exp_t;

`ifdef QA_7SEG_DEC_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int SC = 4;

  logic        clkIn = 1'b0;
  logic        nResetIn;
  logic [41:0] segmentsIn;
  logic        validOut;
  logic        readyIn;
  logic [2:0]  byteEnableOut;
  logic [23:0] byteDataOut;
  logic [5:0]  invalidOut;

  qa_7seg_frame_decoder #(.SETTLE_CYCLES(SC)) dut (
    .clkIn         (clkIn),
    .nResetIn      (nResetIn),
    .segmentsIn    (segmentsIn),
    .validOut      (validOut),
    .readyIn       (readyIn),
    .byteEnableOut (byteEnableOut),
    .byteDataOut   (byteDataOut),
    .invalidOut    (invalidOut)
  );

  always #5 clkIn = ~clkIn;

  logic [6:0] GL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [41:0] enc(input logic [23:0] nibs, input logic [5:0] lit);
    logic [41:0] b;
    for (int k = 0; k < 6; k++)
      b[7*k +: 7] = lit[k] ? ~GL[nibs[4*k +: 4]] : 7'h7F;
    return b;
  endfunction

  function automatic exp_t model(input logic [23:0] nibs, input logic [5:0] lit);
    exp_t e;
    e = '0;
    for (int j = 0; j < 3; j++) begin
      if (lit[2*j] && lit[2*j+1]) begin
        e.en[j]          = 1'b1;
        e.data[8*j +: 8] = nibs[8*j +: 8];
      end else if (lit[2*j] || lit[2*j+1]) begin
        e.inv[2*j +: 2] = 2'b11;
      end
    end
    return e;
  endfunction

  // Transfer check happens on the falling edge ahead of the rising edge that performs it.
  task automatic tick();
    exp_t e;
    @(negedge clkIn);
    if (nResetIn && validOut && readyIn) begin
      if (sb.size() == 0) begin
        chk("spurious_frame", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk("byte_enable", 64'(byteEnableOut), 64'(e.en));
        chk("byte_data",   64'(byteDataOut),   64'(e.data));
        chk("invalid",     64'(invalidOut),    64'(e.inv));
      end
    end
    @(posedge clkIn);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (validOut) begin
        n = i + 1;
        return;
      end
    end
  endtask

  initial begin
    int   n, bad;
    logic [41:0] fa, fb, fc, fd, fx, fy, b4;

    nResetIn   = 1'b0;
    readyIn    = 1'b1;
    segmentsIn = '1;
    repeat (2) @(posedge clkIn);
    #1;
    chk("rst_valid",  64'(validOut),      64'd0);
    chk("rst_enable", 64'(byteEnableOut), 64'd0);
    chk("rst_data",   64'(byteDataOut),   64'd0);
    chk("rst_inv",    64'(invalidOut),    64'd0);

    // blank frame held from reset
    nResetIn = 1'b1;
    sb.push_back(exp_t'('0));
    wait_valid(n);
    chk("t1_latency", 64'(n), 64'(SC + 1));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (validOut) bad++;
    end
    chk("t1_no_repeat", 64'(bad), 64'd0);

    // full frame, then toggling bus that never settles
    fx = enc(24'h12AB3F, 6'h3F);
    fy = enc(24'h000000, 6'h3F);
    segmentsIn = fx;
    sb.push_back(model(24'h12AB3F, 6'h3F));
    wait_valid(n);
    chk("t2_latency", 64'(n), 64'(SC + 2 + EXTRA));
    tick();
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      segmentsIn = (i % 2 == 0) ? fy : fx;
      repeat (3) begin
        tick();
        if (validOut) bad++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (validOut) bad++;
    end
    chk("t2_quiet", 64'(bad), 64'd0);

    // back-pressure: A pending, B overwritten by C, C follows after one low cycle
    readyIn = 1'b0;
    fa = enc(24'h456789, 6'h3F);
    fb = enc(24'hABCDEF, 6'h3F);
    fc = enc(24'h012345, 6'h0F);
    segmentsIn = fa;
    sb.push_back(model(24'h456789, 6'h3F));
    wait_valid(n);
    chk("t3_a_seen", 64'(n > 0), 64'd1);
    segmentsIn = fb;
    repeat (6) tick();
    segmentsIn = fc;
    sb.push_back(model(24'h012345, 6'h0F));
    repeat (6) tick();
    chk("t3_hold_valid", 64'(validOut),    64'd1);
    chk("t3_hold_data",  64'(byteDataOut), 64'h456789);
    readyIn = 1'b1;
    tick();
    chk("t3_gap_low", 64'(validOut), 64'd0);
    tick();
    chk("t3_c_high", 64'(validOut), 64'd1);
    tick();

    // illegal glyph and half-blank byte
    b4 = ~{7'h5E, 7'h79, 7'h3F, 7'h7E, 7'h6D, 7'h00};
    segmentsIn = b4;
    sb.push_back('{en: 3'b110, data: 24'hDE0000, inv: 6'b000111});
    wait_valid(n);
    chk("t4_seen", 64'(n > 0), 64'd1);
    tick();

    // asynchronous reset while pending, then the same frame is reported again
    readyIn = 1'b0;
    fd = enc(24'h0F0F0F, 6'h3F);
    segmentsIn = fd;
    sb.push_back(model(24'h0F0F0F, 6'h3F));
    wait_valid(n);
    chk("t5_seen", 64'(n > 0), 64'd1);
    nResetIn = 1'b0;
    #1;
    chk("t5_async_valid", 64'(validOut),    64'd0);
    chk("t5_async_data",  64'(byteDataOut), 64'd0);
    void'(sb.pop_back());
    @(posedge clkIn);
    #1;
    nResetIn = 1'b1;
    readyIn  = 1'b1;
    sb.push_back(model(24'h0F0F0F, 6'h3F));
    wait_valid(n);
    chk("t5_rereport", 64'(n), 64'(SC + 2 + EXTRA));
    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
